// File: rtl/pl_fetch_queue_if_if.sv
// ---------------------------------------------------------------------------
// pl_fetch_queue_if_if
// Bundle of the fetch-stage bus signals: the instruction-memory request and
// response channel, plus the valid/ready handshake towards ID.
//
// Parameters:
//   XLEN        address / instruction width
//
// Signals:
//   imem_req    fetch request, accepted in the cycle it is high
//   imem_addr   fetch address
//   imem_rvalid response valid (only while a request is outstanding)
//   imem_rdata  returned instruction
//   id_valid    queue head valid
//   id_ready    ID accepts the head
//   id_pc       PC of the head
//   id_p4       id_pc + PC_STEP
//   id_ins      instruction of the head
//
// Modports:
//   master      fetch-stage side (drives the request and the ID outputs)
//   slave       environment side (memory + ID)
// ---------------------------------------------------------------------------
interface pl_fetch_queue_if_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_p4;
  logic [XLEN-1:0] id_ins;

  modport master (
    output imem_req, imem_addr, id_valid, id_pc, id_p4, id_ins,
    input  imem_rvalid, imem_rdata, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_pc, id_p4, id_ins,
    output imem_rvalid, imem_rdata, id_ready
  );
endinterface

// File: rtl/pl_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// pl_fetch_queue_if
// Instruction-fetch stage of the pipelined RISC-V core. Owns the PC register,
// picks the next fetch PC (sequential / branch / JALR / JAL), keeps at most one
// request outstanding to a variable-latency instruction memory and buffers the
// returned instructions in a FIFO fetch queue that feeds ID over valid/ready.
// Any redirect flushes the queue and kills the in-flight fetch.
//
// Parameters:
//   XLEN      address / instruction width
//   RESET_PC  fetch PC after reset
//   FQ_DEPTH  fetch-queue entries (power of 2, >= 2)
//   PC_STEP   sequential increment
//
// Ports:
//   clk       rising-edge clock
//   clrn      asynchronous active-low reset
//   pcsrc     0 sequential, 1 bra, 2 jalra, 3 jala (nonzero = redirect)
//   bra       branch target
//   jalra     JALR target
//   jala      JAL target
//   bus       pl_fetch_queue_if_if.master (imem request/response, ID handshake)
//   fq_count  current fetch-queue occupancy
//
// Build option:
//   FQ_BYPASS_EN  when defined, a response arriving into an empty queue while
//                 ID is ready is forwarded combinationally instead of queued.
// ---------------------------------------------------------------------------
module pl_fetch_queue_if #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              FQ_DEPTH = 4,
  parameter int              PC_STEP  = 4
) (
  input  logic                        clk,
  input  logic                        clrn,
  input  logic [1:0]                  pcsrc,
  input  logic [XLEN-1:0]             bra,
  input  logic [XLEN-1:0]             jalra,
  input  logic [XLEN-1:0]             jala,
  pl_fetch_queue_if_if.master         bus,
  output logic [$clog2(FQ_DEPTH):0]   fq_count
);

  localparam int              AW      = $clog2(FQ_DEPTH);
  localparam logic [AW:0]     DEPTH_C = (AW+1)'(FQ_DEPTH);
  localparam logic [AW:0]     ONE_C   = (AW+1)'(1);
  localparam logic [AW-1:0]   PTR_INC = AW'(1);
  localparam logic [XLEN-1:0] STEP    = XLEN'(PC_STEP);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc, tag, raw_target, target;
  logic [XLEN-1:0] q_pc  [FQ_DEPTH];
  logic [XLEN-1:0] q_ins [FQ_DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [AW:0]     count;
  logic            redirect, issue, resp_keep, bypass, push, pop;
  logic            id_valid_w;
  logic [XLEN-1:0] id_pc_w, id_ins_w;

  // Redirect target; the low two bits are cleared before it reaches the PC.
  always_comb begin
    raw_target = jala;
    unique case (pcsrc)
      2'd1:    raw_target = bra;
      2'd2:    raw_target = jalra;
      default: raw_target = jala;
    endcase
    target = raw_target & ~XLEN'(3);
  end

  // Issue only from IDLE, so a free queue slot is implicitly reserved for the
  // single outstanding request. Gating with clrn keeps imem_req low in reset.
  assign redirect  = (pcsrc != 2'd0);
  assign issue     = clrn && (state == IDLE) && (count < DEPTH_C) && !redirect;
  assign resp_keep = (state == WAIT) && bus.imem_rvalid && !redirect;

`ifdef FQ_BYPASS_EN
  assign bypass = resp_keep && (count == '0) && bus.id_ready;
`else
  assign bypass = 1'b0;
`endif

  assign push = resp_keep && !bypass;
  assign pop  = (count != '0) && bus.id_ready && !redirect;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= state_nxt;
  end

  // A redirect while waiting turns the outstanding response into one to drop,
  // unless it is returning in that very cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (issue) state_nxt = WAIT;
      WAIT: begin
        if (redirect)              state_nxt = bus.imem_rvalid ? IDLE : DROP;
        else if (bus.imem_rvalid)  state_nxt = IDLE;
      end
      DROP: if (bus.imem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // tag remembers the PC of the outstanding request.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pc  <= RESET_PC;
      tag <= '0;
    end else if (redirect) begin
      pc <= target;
    end else if (issue) begin
      tag <= pc;
      pc  <= pc + STEP;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (redirect) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_INC;
      if (pop)  rptr <= rptr + PTR_INC;
      if (push && !pop)      count <= count + ONE_C;
      else if (pop && !push) count <= count - ONE_C;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wptr]  <= tag;
      q_ins[wptr] <= bus.imem_rdata;
    end
  end

  // Head outputs read as zero while nothing is valid.
  always_comb begin
    id_valid_w = 1'b0;
    id_pc_w    = '0;
    id_ins_w   = '0;
    if (count != '0) begin
      id_valid_w = 1'b1;
      id_pc_w    = q_pc[rptr];
      id_ins_w   = q_ins[rptr];
    end else if (bypass) begin
      id_valid_w = 1'b1;
      id_pc_w    = tag;
      id_ins_w   = bus.imem_rdata;
    end
  end

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc;
  assign bus.id_valid  = id_valid_w;
  assign bus.id_pc     = id_pc_w;
  assign bus.id_ins    = id_ins_w;
  assign bus.id_p4     = id_valid_w ? (id_pc_w + STEP) : '0;
  assign fq_count      = count;

endmodule

// File: tb/tb_pl_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// tb_pl_fetch_queue_if
// Bench for pl_fetch_queue_if: a variable-latency instruction memory model,
// a scoreboard of expected ID-side entries and a reference fetch-PC model.
// Honours FQ_BYPASS_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_pl_fetch_queue_if;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] p4;
    logic [31:0] ins;
  } exp_t;

  logic        clk  = 1'b0;
  logic        clrn = 1'b1;
  logic [1:0]  pcsrc = 2'd0;
  logic [31:0] bra   = '0;
  logic [31:0] jalra = '0;
  logic [31:0] jala  = '0;
  logic [2:0]  fq_count;

  pl_fetch_queue_if_if #(.XLEN(XLEN)) bus();

  pl_fetch_queue_if #(
    .XLEN(XLEN), .RESET_PC(32'h0000_0000), .FQ_DEPTH(DEPTH), .PC_STEP(4)
  ) dut (
    .clk(clk), .clrn(clrn), .pcsrc(pcsrc), .bra(bra), .jalra(jalra),
    .jala(jala), .bus(bus), .fq_count(fq_count)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  exp_t        sb[$];
  logic [31:0] popLog[$];
  logic [31:0] reqLog[$];
  logic [31:0] expPc;
  bit          memOut, memDropped;
  logic [31:0] memAddr;
  int          memWait, memLat, popCount;

  function automatic logic [31:0] insOf(input logic [31:0] a);
    return a ^ 32'h5EED_0013;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One clock cycle: check outputs at the falling edge against the models,
  // then advance the memory model just after the rising edge.
  task automatic runCycle();
    int          sizeBefore;
    bit          redirect, kept, expValid, expReq;
    logic [31:0] tgt;
    exp_t        e;
    @(negedge clk);
    redirect   = (pcsrc != 2'd0);
    sizeBefore = sb.size();
    expReq     = !memOut && (sizeBefore < DEPTH) && !redirect;
    checkOutput("fq_count", 32'(fq_count), 32'(sizeBefore));
    checkOutput("imem_req", 32'(bus.imem_req), 32'(expReq));
    kept = bus.imem_rvalid && !memDropped && !redirect;
    if (kept) sb.push_back('{memAddr, memAddr + 32'd4, insOf(memAddr)});
    expValid = (sizeBefore != 0);
`ifdef FQ_BYPASS_EN
    if (sizeBefore == 0 && kept && bus.id_ready) expValid = 1'b1;
`endif
    checkOutput("id_valid", 32'(bus.id_valid), 32'(expValid));
    if (expValid && sb.size() > 0) begin
      e = sb[0];
      checkOutput("id_pc", bus.id_pc, e.pc);
      checkOutput("id_p4", bus.id_p4, e.p4);
      checkOutput("id_ins", bus.id_ins, e.ins);
      if (bus.id_ready && !redirect) begin
        void'(sb.pop_front());
        popLog.push_back(e.pc);
        popCount++;
      end
    end
    if (bus.imem_rvalid) memOut = 1'b0;
    if (bus.imem_req) begin
      checkOutput("imem_addr", bus.imem_addr, expPc);
      reqLog.push_back(bus.imem_addr);
      expPc      = expPc + 32'd4;
      memOut     = 1'b1;
      memDropped = 1'b0;
      memAddr    = bus.imem_addr;
      memWait    = memLat;
    end
    if (redirect) begin
      tgt = (pcsrc == 2'd1) ? bra : (pcsrc == 2'd2) ? jalra : jala;
      if (memOut) memDropped = 1'b1;
      sb.delete();
      expPc = tgt & ~32'd3;
    end
    @(posedge clk);
    #1;
    bus.imem_rvalid = 1'b0;
    if (memOut && memWait > 0) begin
      memWait--;
      if (memWait == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = insOf(memAddr);
      end
    end
  endtask

  // Unselected target ports carry junk so a wrong select shows up.
  task automatic applyStimulus(input logic [1:0] sel, input logic [31:0] tgt,
                               input bit rdy, input int cycles);
    pcsrc        = sel;
    bra          = (sel == 2'd1) ? tgt : 32'hDEAD_0100;
    jalra        = (sel == 2'd2) ? tgt : 32'hDEAD_0200;
    jala         = (sel == 2'd3) ? tgt : 32'hDEAD_0300;
    bus.id_ready = rdy;
    repeat (cycles) runCycle();
  endtask

  task automatic doReset();
    clrn            = 1'b0;
    pcsrc           = 2'd0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.id_ready    = 1'b1;
    memOut          = 1'b0;
    memDropped      = 1'b0;
    memWait         = 0;
    expPc           = 32'h0;
    sb.delete();
    @(negedge clk);
    checkOutput("rst_imem_req", 32'(bus.imem_req), 32'd0);
    checkOutput("rst_id_valid", 32'(bus.id_valid), 32'd0);
    checkOutput("rst_fq_count", 32'(fq_count), 32'd0);
    checkOutput("rst_id_pc", bus.id_pc, 32'd0);
    checkOutput("rst_id_p4", bus.id_p4, 32'd0);
    checkOutput("rst_id_ins", bus.id_ins, 32'd0);
    @(posedge clk);
    #1;
    clrn = 1'b1;
  endtask

  initial begin
    int guard;
    bit rdy;
    memLat = 1;
    popCount = 0;

    // Sequential streaming with a 1-cycle memory.
    doReset();
    popLog.delete();
    applyStimulus(2'd0, 32'h0, 1'b1, 12);
    checkOutput("seq_pops", 32'(popCount >= 5), 32'd1);
    checkOutput("seq_pc0", (popLog.size() > 0) ? popLog[0] : 32'hFFFF_FFFF, 32'h0);
    checkOutput("seq_pc2", (popLog.size() > 2) ? popLog[2] : 32'hFFFF_FFFF, 32'h8);

    // Fill the queue with ID stalled, then release a single entry.
    doReset();
    applyStimulus(2'd0, 32'h0, 1'b0, 14);
    checkOutput("full_count", 32'(fq_count), 32'd4);
    checkOutput("full_req", 32'(bus.imem_req), 32'd0);
    reqLog.delete();
    applyStimulus(2'd0, 32'h0, 1'b1, 1);
    applyStimulus(2'd0, 32'h0, 1'b0, 4);
    checkOutput("refetch_addr", (reqLog.size() > 0) ? reqLog[0] : 32'hFFFF_FFFF, 32'h10);

    // Branch while the fetch of 0x8 is outstanding on a 3-cycle memory.
    doReset();
    memLat = 3;
    guard = 0;
    while (!(memOut && memAddr == 32'h8) && guard < 40) begin
      applyStimulus(2'd0, 32'h0, 1'b1, 1);
      guard++;
    end
    checkOutput("reach_0x8", 32'(guard < 40), 32'd1);
    popLog.delete();
    reqLog.delete();
    applyStimulus(2'd1, 32'h100, 1'b1, 1);
    checkOutput("flush_count", 32'(fq_count), 32'd0);
    applyStimulus(2'd0, 32'h0, 1'b1, 15);
    checkOutput("bra_addr", (reqLog.size() > 0) ? reqLog[0] : 32'hFFFF_FFFF, 32'h100);
    checkOutput("bra_pc", (popLog.size() > 0) ? popLog[0] : 32'hFFFF_FFFF, 32'h100);

    // JAL coinciding with a returning response.
    doReset();
    memLat = 2;
    guard = 0;
    while (!bus.imem_rvalid && guard < 40) begin
      applyStimulus(2'd0, 32'h0, 1'b1, 1);
      guard++;
    end
    checkOutput("reach_rvalid", 32'(guard < 40), 32'd1);
    reqLog.delete();
    applyStimulus(2'd3, 32'h203, 1'b1, 1);
    applyStimulus(2'd0, 32'h0, 1'b1, 6);
    checkOutput("jal_addr", (reqLog.size() > 0) ? reqLog[0] : 32'hFFFF_FFFF, 32'h200);

    // Push and pop together at occupancy 2, then randomised streaming.
    doReset();
    memLat = 1;
    guard = 0;
    while (!(sb.size() == 2 && bus.imem_rvalid) && guard < 30) begin
      applyStimulus(2'd0, 32'h0, 1'b0, 1);
      guard++;
    end
    checkOutput("reach_cnt2", 32'(guard < 30), 32'd1);
    applyStimulus(2'd0, 32'h0, 1'b1, 1);
    checkOutput("pushpop_count", 32'(fq_count), 32'd2);
    popCount = 0;
    for (int i = 0; i < 120; i++) begin
      memLat = $urandom_range(1, 3);
      rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0)
        applyStimulus(2'($urandom_range(1, 3)), $urandom, rdy, 1);
      else
        applyStimulus(2'd0, 32'h0, rdy, 1);
    end
    checkOutput("stream_pops", 32'(popCount >= 10), 32'd1);

    // JALR to the top of the address space: p4 and the next PC wrap to 0.
    doReset();
    memLat = 1;
    reqLog.delete();
    applyStimulus(2'd2, 32'hFFFF_FFFC, 1'b1, 1);
    applyStimulus(2'd0, 32'h0, 1'b1, 8);
    checkOutput("wrap_addr0", (reqLog.size() > 0) ? reqLog[0] : 32'h1, 32'hFFFF_FFFC);
    checkOutput("wrap_addr1", (reqLog.size() > 1) ? reqLog[1] : 32'h1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pl_fetch_queue_if.md
Name: pl_fetch_queue_if

Overview:
- Parametrised, sequential instruction-fetch stage for the pipelined RISC-V core.
- Owns the PC register and selects the next fetch PC from sequential / branch / JALR / JAL targets.
- Issues requests to an instruction memory with variable response latency and buffers returned instructions in a FIFO fetch queue.
- Presents {pc, p4, ins} to ID over a valid/ready handshake. Redirects flush the queue and kill any in-flight fetch.

Parameters:
- XLEN, 32, address/instruction width.
- RESET_PC, 32'h0000_0000, fetch PC after reset.
- FQ_DEPTH, 4, fetch-queue entries; power of 2, >=2.
- PC_STEP, 4, sequential increment.

Ports:
- clk  in  1  rising-edge clock.
- clrn  in  1  asynchronous active-low reset.
- pcsrc  in  2  0 = sequential; 1 = bra; 2 = jalra; 3 = jala (nonzero = redirect).
- bra  in  XLEN  branch target.
- jalra  in  XLEN  JALR target.
- jala  in  XLEN  JAL target.
- imem_req  out  1  fetch request; accepted the cycle it is high.
- imem_addr  out  XLEN  fetch address (= fetch PC).
- imem_rvalid  in  1  response valid; only while a request is outstanding.
- imem_rdata  in  XLEN  returned instruction.
- id_valid  out  1  queue head valid.
- id_ready  in  1  ID accepts head.
- id_pc  out  XLEN  PC of head.
- id_p4  out  XLEN  id_pc + PC_STEP.
- id_ins  out  XLEN  instruction of head.
- fq_count  out  log2(FQ_DEPTH)+1  current occupancy.

Behaviour:
- Reset (clrn low, async): fetch PC = RESET_PC, state IDLE, queue empty, fq_count = 0, id_valid = 0, imem_req = 0. id_pc / id_p4 / id_ins = 0.
- Clock and reset: one clock, clk; reset asynchronous, active-low, clrn.
- Target selection: redirect target = bra / jalra / jala per pcsrc. Bits [1:0] of the target are forced to 0 before loading.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding; response will be kept.
  - DROP: one request outstanding; response will be discarded.
- imem_req = (state == IDLE) && (fq_count < FQ_DEPTH) && (pcsrc == 0). At most one outstanding request.
- IDLE + imem_req -> WAIT. Fetch PC is captured as the tag for the outstanding request and advances by PC_STEP.
- WAIT + imem_rvalid, no redirect: push {tag, imem_rdata} -> IDLE.
- WAIT + redirect (with or without rvalid that cycle): no push -> DROP if rvalid = 0, else -> IDLE.
- DROP + imem_rvalid -> IDLE; data discarded. DROP + redirect stays DROP, with the PC updated.
- Redirect (pcsrc != 0) in any state:
  - fetch PC <= target next edge;
  - queue flushed to empty (fq_count = 0);
  - no request issued that cycle;
  - id_valid may still be high that cycle; a pop that cycle is ignored by ID's own flush.
- Pop occurs when id_valid && id_ready. Push and pop in the same cycle leave fq_count unchanged.
- Full: fq_count == FQ_DEPTH blocks issue. Slot reservation is implicit because issue happens only from IDLE.
- Empty: id_valid = 0; id_ready is ignored.
- Pointers wrap modulo FQ_DEPTH. id_p4 is computed mod 2^XLEN, so 32'hFFFF_FFFC + 4 = 0.
- Latency:
  - without FQ_BYPASS_EN, the earliest id_valid is 1 cycle after the imem_rvalid edge;
  - back-to-back throughput is 1 instruction per (memory latency + 1) cycles.

Optional Feature:
- Macro FQ_BYPASS_EN.
- When defined: if the queue is empty, state is WAIT, imem_rvalid = 1, no redirect, and id_ready = 1, the response is forwarded combinationally:
  - id_valid = 1, id_ins = imem_rdata, id_pc = tag, same cycle;
  - the entry is not written, and fq_count is unchanged.
- If id_ready = 0 in that case, the entry is pushed normally.
- When undefined: every response goes through the queue; no combinational path from imem_rdata/imem_rvalid to the id_* outputs.

Test Plan:
- Reset, 1-cycle memory, id_ready = 1 -> imem_addr sequence 0x0, 0x4, 0x8; ID receives pc 0x0/0x4/0x8 with p4 0x4/0x8/0xC, in order, no gaps beyond one per 2 cycles.
- id_ready = 0 held, FQ_DEPTH = 4 -> exactly 4 pushes; fq_count = 4; imem_req stays 0 until one pop, then one more fetch at 0x10.
- Request to 0x8 outstanding with 3-cycle latency; pcsrc = 1, bra = 0x100 at cycle 1 -> queue empties; returned 0x8 data dropped; next imem_addr = 0x100; first id_pc = 0x100.
- Redirect coincident with imem_rvalid in WAIT, jala = 0x203 -> no push; next fetch at 0x200, state IDLE.
- Simultaneous push and pop at fq_count = 2 -> fq_count stays 2; FIFO order preserved across pointer wrap (10+ entries streamed).
- With FQ_BYPASS_EN, empty queue, rvalid with id_ready = 1 -> id_valid and id_ins = imem_rdata in the same cycle, fq_count = 0. Without the macro, the same stimulus gives id_valid one cycle later.
